// File: rtl/rng_share_ctrl.sv
// Seeds an external RNG, discards warm-up samples, then hands every sample to
// exactly one requester in round-robin order so each consumer gets an independent stream.
module rng_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int XW     = 12,
  parameter int WARMUP = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [23:0]     seed_a,
  input  logic [15:0]     seed_b,
  output logic [23:0]     rng_data,
  output logic [15:0]     rng_data2,
  output logic            rng_run,
  input  logic [XW-1:0]   rng_x,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [XW-1:0]   sample,
  output logic            sample_valid,
  output logic            ready,
  output logic [15:0]     drop_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, SERVE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      warm_cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] gnt_nxt;
  logic            serve_p0;
  int              idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search starting one past the last granted requester
  always_comb begin
    pick    = ptr;
    found   = 1'b0;
    gnt_nxt = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PW'(idx)]) begin
        found   = 1'b1;
        pick    = PW'(idx);
        gnt_nxt = NREQ'(1) << idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rng_run   = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE:  if (seed_load) state_nxt = LOAD;
      LOAD:  state_nxt = WARM;
      WARM: begin
        rng_run = 1'b1;
        if (seed_load)                  state_nxt = LOAD;
        else if (warm_cnt == WARM_LAST) state_nxt = SERVE;
      end
      SERVE: begin
        rng_run = 1'b1;
        ready   = 1'b1;
        if (seed_load) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A reseed pre-empts serving on the same edge, so grants drop the next cycle
  assign serve_p0 = (state == SERVE) && !seed_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rng_data     <= '0;
      rng_data2    <= '0;
      warm_cnt     <= '0;
      ptr          <= PW'(NREQ - 1);
      gnt          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (seed_load && state != LOAD) begin
        rng_data  <= seed_a;
        rng_data2 <= seed_b;
      end
      warm_cnt     <= (state == WARM) ? warm_cnt + 8'd1 : '0;
      gnt          <= serve_p0 ? gnt_nxt : '0;
      sample_valid <= serve_p0 && found;
      if (serve_p0) begin
        sample <= rng_x;
        if (found) ptr      <= pick;
        else       drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl; a small RNG stand-in produces samples from
// the seeds it is loaded with, and expectations come from the bench's own constants.
module tb_rng_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        seed_load = 1'b0;
  logic [23:0] seed_a = '0;
  logic [15:0] seed_b = '0;
  logic [23:0] rng_data;
  logic [15:0] rng_data2;
  logic        rng_run;
  logic [11:0] rng_x;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [11:0] sample;
  logic        sample_valid;
  logic        ready;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_bad = 0;

  rng_share_ctrl #(.NREQ(4), .XW(12), .WARMUP(6)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_a(seed_a), .seed_b(seed_b),
    .rng_data(rng_data), .rng_data2(rng_data2), .rng_run(rng_run), .rng_x(rng_x),
    .req(req), .gnt(gnt), .sample(sample), .sample_valid(sample_valid),
    .ready(ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] gold(input logic [23:0] a, input logic [15:0] b, input int n);
    logic [11:0] base;
    base = a[23:12] ^ a[11:0] ^ b[11:0] ^ {b[15:12], 8'h00};
    return base + 12'(n * 937);
  endfunction

  // RNG stand-in: reloads while held stopped, advances one step per running clock
  logic [23:0] st_a = '0;
  logic [15:0] st_b = '0;
  int          st_n = 0;
  always @(posedge clk) begin
    if (!rng_run) begin
      st_a <= rng_data;
      st_b <= rng_data2;
      st_n <= 0;
    end else begin
      st_n <= st_n + 1;
    end
  end
  assign rng_x = gold(st_a, st_b, st_n);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [23:0] SA1 = 24'h6ABE62;
  localparam logic [15:0] SB1 = 16'h223D;
  localparam logic [23:0] SA2 = 24'h123456;
  localparam logic [15:0] SB2 = 16'hBEEF;

  initial begin
    int g;
    int bad_idle;
    logic [3:0] exp_g;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    check_val("rst_run", rng_run, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_sv", sample_valid, 0);
    check_val("rst_ready", ready, 0);
    check_val("rst_drop", drop_cnt, 0);
    check_val("rst_data", rng_data, 0);
    check_val("rst_sample", sample, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_val("idle_run", rng_run, 0);

    // Seed load, then the single LOAD cycle
    seed_a = SA1; seed_b = SB1; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 4'b1111;
    check_val("load_run", rng_run, 0);
    check_val("load_data", rng_data, SA1);
    check_val("load_data2", rng_data2, SB1);
    check_val("load_ready", ready, 0);
    tick();

    // Warm-up: RNG running, nothing served even though req is active
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("warm_run%0d", i), rng_run, 1);
      check_val($sformatf("warm_ready%0d", i), ready, 0);
      check_val($sformatf("warm_gnt%0d", i), gnt, 0);
      check_val($sformatf("warm_data%0d", i), rng_data, SA1);
      tick();
    end
    check_val("serve_ready", ready, 1);
    check_val("serve_gnt0", gnt, 0);

    // All requesting: strict rotation starting at requester 0
    g = 6;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 4'b0001 << (k % 4);
      check_val($sformatf("rr_gnt%0d", k), gnt, exp_g);
      check_val($sformatf("rr_sv%0d", k), sample_valid, 1);
      check_val($sformatf("rr_smp%0d", k), sample, gold(SA1, SB1, g));
      g++;
    end

    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      check_val($sformatf("alt_gnt%0d", k), gnt, exp_g);
      check_val($sformatf("alt_smp%0d", k), sample, gold(SA1, SB1, g));
      g++;
    end
    req = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val($sformatf("one_gnt%0d", k), gnt, 4'b0001);
      check_val($sformatf("one_sv%0d", k), sample_valid, 1);
      g++;
    end

    // No requesters: every sample dropped, counter saturates
    req = 4'b0000;
    bad_idle = 0;
    for (int k = 0; k < 65534; k++) begin
      tick();
      if (sample_valid !== 1'b0 || gnt !== 4'b0000) bad_idle++;
    end
    g += 65534;
    check_val("drop_fffe", drop_cnt, 16'hFFFE);
    tick();
    g++;
    check_val("drop_ffff", drop_cnt, 16'hFFFF);
    for (int k = 0; k < 4465; k++) begin
      tick();
      if (sample_valid !== 1'b0 || gnt !== 4'b0000) bad_idle++;
    end
    g += 4465;
    check_val("drop_sat", drop_cnt, 16'hFFFF);
    check_val("idle_sv", bad_idle, 0);
    check_val("idle_ready", ready, 1);

    // Pointer was left at requester 0
    req = 4'b1111;
    tick();
    check_val("resume_gnt", gnt, 4'b0010);
    check_val("resume_smp", sample, gold(SA1, SB1, g));

    // Reseed mid-SERVE; a second seed_load during LOAD must be ignored
    seed_a = SA2; seed_b = SB2; seed_load = 1'b1;
    tick();
    check_val("rs_gnt", gnt, 0);
    check_val("rs_sv", sample_valid, 0);
    check_val("rs_run", rng_run, 0);
    check_val("rs_data", rng_data, SA2);
    check_val("rs_data2", rng_data2, SB2);
    check_val("rs_drop", drop_cnt, 16'hFFFF);
    seed_a = 24'hFFFFFF; seed_b = 16'h0000;
    tick();
    seed_load = 1'b0;
    check_val("rs_ign_data", rng_data, SA2);
    check_val("rs_ign_data2", rng_data2, SB2);
    check_val("rs_warm_run", rng_run, 1);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("rs_warm_gnt%0d", i), gnt, 0);
      tick();
    end
    check_val("rs_ready", ready, 1);
    g = 6;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_g = (k == 0) ? 4'b0100 : (k == 1) ? 4'b1000 : 4'b0001;
      check_val($sformatf("rs_gnt%0d", k), gnt, exp_g);
      check_val($sformatf("rs_smp%0d", k), sample, gold(SA2, SB2, g));
      g++;
    end

    // Asynchronous reset between clock edges during WARM
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    check_val("pre_ar_run", rng_run, 1);
    #3 reset = 1'b1;
    #1;
    check_val("ar_run", rng_run, 0);
    check_val("ar_gnt", gnt, 0);
    check_val("ar_sv", sample_valid, 0);
    check_val("ar_ready", ready, 0);
    check_val("ar_drop", drop_cnt, 0);
    check_val("ar_data", rng_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("ar_idle_run%0d", i), rng_run, 0);
      check_val($sformatf("ar_idle_ready%0d", i), ready, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
